// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with valid/ready handshake and flush.
// in_ready, out_valid and count are all flop-driven so no ready path crosses the stage.
module pipe_skid_stage #(
  parameter int unsigned            WIDTH   = 32,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;
  logic             in_fire, out_fire;

  // Next state and payload movement; outputs are pre-decoded from the next state.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    s_d         = s_q;
    in_fire     = in_valid & in_ready_q;
    out_fire    = out_valid_q & out_ready;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          m_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          s_d     = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush drops occupancy only; stale payload contents are don't-care.
    if (flush) begin
      state_d = EMPTY;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    unique case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      m_q         <= RST_VAL;
      s_q         <= RST_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: queue-based occupancy model checked every
// cycle, plus literal expectations for reset, streaming, backpressure and flush.
module tb_pipe_skid_stage;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] RST_VAL = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        chk_en = 1'b0;

  logic [WIDTH-1:0] mdl_q[$];
  logic [WIDTH-1:0] dut_log[$];

  pipe_skid_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two beats; head is what downstream must see.
  always @(posedge clk) begin
    if (rst) begin
      mdl_q.delete();
    end else if (flush) begin
      mdl_q.delete();
    end else begin
      bit can_in;
      can_in = (mdl_q.size() < 2);
      if (mdl_q.size() != 0 && out_ready) void'(mdl_q.pop_front());
      if (in_valid && can_in) mdl_q.push_back(in_data);
    end
  end

  // Per-cycle comparison against the model, plus a log of beats handed downstream.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mdl_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(mdl_q.size() < 2));
      chk("count", 32'(count), 32'(mdl_q.size()));
      if (mdl_q.size() != 0) chk("out_data", out_data, mdl_q[0]);
      if (!in_ready) chk("not_ready_only_when_full", 32'(count), 32'd2);
      if (out_valid && out_ready && !rst) dut_log.push_back(out_data);
    end
  end

  // Apply inputs for the next edge, then move to just after that edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic o,
                      input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    flush     = f;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_tail(input string nm, input logic [WIDTH-1:0] exp[$]);
    int n;
    n = exp.size();
    chk({nm, "_len"}, 32'(dut_log.size() >= n), 32'd1);
    if (dut_log.size() >= n)
      for (int i = 0; i < n; i++)
        chk(nm, dut_log[dut_log.size() - n + i], exp[i]);
  endtask

  initial begin
    logic [WIDTH-1:0] exp[$];

    // Reset held for two cycles with a valid beat on the input.
    step(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", out_data, 32'h0000_0000);

    // Streaming 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_latency", out_data, WIDTH'(i));
      chk("stream_count", 32'(count), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    exp = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
    chk_tail("stream_order", exp);

    // Backpressure: 0x10 in M, 0x11 skidded, 0x12 held upstream.
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("bp_ready_after_first", 32'(in_ready), 32'd1);
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    chk("bp_head", out_data, 32'h10);
    chk("bp_count", 32'(count), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    chk("bp_second", out_data, 32'h11);
    step(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    chk("bp_third", out_data, 32'h12);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    exp = {32'h10, 32'h11, 32'h12};
    chk_tail("bp_order", exp);

    // Flush while FULL with 0x20 offered on the flush edge.
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 32'h21, 1'b1, 1'b0, 1'b0);
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_data", out_data, 32'h21);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    exp = {32'h12, 32'h21};
    chk_tail("flush_order", exp);

    // Reset and flush together while BUSY: reset wins.
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h41, 1'b0, 1'b1, 1'b1);
    chk("rst_flush_data", out_data, RST_VAL);
    chk("rst_flush_count", 32'(count), 32'd0);
    chk("rst_flush_valid", 32'(out_valid), 32'd0);

    // Reset mid-FULL: nothing emerges afterwards.
    step(1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h51, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_log_tail", dut_log[dut_log.size() - 1], 32'h21);

    // Random handshake traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0), 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Two-entry skid-buffered pipeline stage with valid/ready handshake and synchronous flush, used between adjacent `mycpu` pipeline stages (e.g. IF→ID, ID→EX) wherever a plain enabled register stage would put a combinational ready path across the stage boundary. It registers the upstream payload, presents it downstream with `out_valid`, and absorbs one extra beat when downstream stalls. `in_ready` is therefore driven purely from flops. Flush discards all in-flight beats on branch or exception redirect.

## Interface
- `WIDTH`, 32, payload width in bits (instruction, PC, and control packed by the instantiating stage)
- `RST_VAL`, 0, value loaded into both payload registers on reset
- `clk`  input  1  single clock; all state changes on rising edge
- `rst`  input  1  reset, synchronous, active-high; overrides every other input
- `flush`  input  1  discard all held beats this edge; synchronous
- `in_valid`  input  1  upstream payload valid
- `in_ready`  output  1  stage can accept a beat; registered
- `in_data`  input  WIDTH  upstream payload
- `out_valid`  output  1  `out_data` holds a valid beat
- `out_ready`  input  1  downstream accepts the beat this cycle
- `out_data`  output  WIDTH  payload; driven directly from the main register
- `count`  output  2  occupancy, 0..2; registered

## Operation
- Storage: main register M (drives `out_data`) and skid register S. State: EMPTY (count 0), BUSY (M valid, count 1), FULL (M and S valid, count 2).
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- `in_ready = (state != FULL)`. `out_valid = (state != EMPTY)`.
- EMPTY: `in_fire` → M←`in_data`, go to BUSY. Otherwise stay.
- BUSY:
  - `in_fire & out_fire` → M←`in_data`, stay in BUSY.
  - `out_fire` only → EMPTY.
  - `in_fire` only → S←`in_data`, go to FULL.
  - Neither → stay.
- FULL: `in_fire` is impossible because `in_ready` is 0. `out_fire` → M←S, go to BUSY. Otherwise stay; M and S hold.
- `flush` (no `rst`): next state EMPTY and count 0, regardless of handshake. Any `in_fire` on the same edge is dropped. M and S keep their contents, but those contents are don't-care.
- `rst`: state EMPTY, count 0, M = S = `RST_VAL`. Priority is `rst` > `flush` > handshake.
- Data ordering is strictly FIFO. No beat is duplicated or lost except by flush or reset.
- No valid or data dropping under `in_valid` while `in_ready` is 0. Upstream must hold `in_data` stable until it is accepted. The block does not check this.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `count` = 0, `out_data` = `RST_VAL`. These hold in the cycle after the `rst` edge.
- Latency: a beat accepted at edge N appears on `out_valid`/`out_data` in cycle N+1 when the stage was EMPTY or BUSY-and-draining.
- Throughput: one beat per cycle sustained while `out_ready` = 1.
- `in_ready` falls one cycle after the first stalled acceptance. The skid register absorbs the beat accepted in that cycle.
- No combinational path from `out_ready` or `in_valid` to `in_ready` or `out_valid`. All outputs are flop-driven.
- After `flush` at edge N: `out_valid` = 0 and `in_ready` = 1 from cycle N+1. A beat can be accepted at edge N+1.
- Reset asserted mid-FULL: state returns to EMPTY at the next edge. No beat emerges afterward.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid` = 1 and `in_data` = 0xAAAA_AAAA → `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_data` = 0x0000_0000.
- Streaming: `out_ready` = 1, feed 0x1..0x8 back-to-back → the same values appear on consecutive cycles, 1-cycle latency, `in_ready` stays 1, `count` stays 1.
- Backpressure: send 0x10, 0x11, 0x12 with `out_ready` = 0 →
  - 0x10 is held in M and 0x11 in S.
  - `count` = 2 and `in_ready` = 0; 0x12 is held upstream.
  - Release `out_ready` → 0x10, 0x11, 0x12 emerge in order, with no gaps after the first.
- Flush while FULL, with `in_valid` = 1 carrying 0x20 on the flush edge → next cycle `out_valid` = 0, `count` = 0, `in_ready` = 1. 0x20 never appears. A following 0x21 emerges 1 cycle after acceptance.
- `rst` and `flush` asserted together in BUSY → reset result: `out_data` = `RST_VAL`, `count` = 0.
- Random `in_valid`/`out_ready` over 10k cycles against a FIFO scoreboard → no loss, duplication, or reordering. `count` never exceeds 2. `in_ready` = 0 only when `count` = 2.
